// File: rtl/ppcpu_wb_pkg.sv
// rtl/ppcpu_wb_pkg.sv - shared Wishbone master types and widths
package ppcpu_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    // Address field is sized for the widest bus; narrower masters zero-extend.
    typedef struct packed {
        logic                 we;
        logic [WB_ADDR_W-1:0] adr;
        logic [WB_DATA_W-1:0] dat;
        logic [WB_SEL_W-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_master_bridge_if.sv
// rtl/wb_master_bridge_if.sv - request/response and Wishbone signal bundle
interface wb_master_bridge_if #(
    parameter int ADDR_W = 32
);
    import ppcpu_wb_pkg::*;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [ADDR_W-1:0]    req_adr_i;
    logic [WB_DATA_W-1:0] req_dat_i;
    logic [WB_SEL_W-1:0]  req_sel_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [WB_DATA_W-1:0] rsp_dat_o;
    logic                 rsp_err_o;

    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic                 wb_we_o;
    logic [WB_SEL_W-1:0]  wb_sel_o;
    logic [ADDR_W-1:0]    wb_adr_o;
    logic [WB_DATA_W-1:0] wb_dat_o;
    logic [WB_DATA_W-1:0] wb_dat_i;
    logic                 wb_ack_i;
    logic                 wb_err_i;

    // master: the bridge (Wishbone initiator); slave: requester plus bus target
    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );

endinterface

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating bus-cycle timeout counter
module wb_timeout_cnt #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic match
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LIMIT_V)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // LIMIT of zero means "wait forever": the counter parks at 0 and never matches.
    assign match = (LIMIT != 0) && (cnt_q == LIMIT_V);

endmodule

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - single-cycle Wishbone classic initiator with timeout
module wb_master_bridge
    import ppcpu_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    wb_master_bridge_if.master        bus,
    output logic                      busy_o
);

    wb_state_e            state_q, state_d;
    wb_req_t              req_q, req_d;
    logic                 cyc_q, cyc_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WB_DATA_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 cnt_clr, cnt_en, to_match;

    wb_timeout_cnt #(
        .W     (TO_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .match (to_match)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    req_d.we  = bus.req_we_i;
                    req_d.adr = WB_ADDR_W'(bus.req_adr_i);
                    req_d.dat = bus.req_dat_i;
                    req_d.sel = bus.req_sel_i;
                    cyc_d     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                // Slave termination beats the timeout; err beats ack.
                if (bus.wb_err_i || (!bus.wb_ack_i && to_match)) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end else if (bus.wb_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = req_q.we ? '0 : bus.wb_dat_i;
                    state_d     = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);

    assign bus.wb_cyc_o = cyc_q;
    assign bus.wb_stb_o = cyc_q;
    assign bus.wb_we_o  = req_q.we;
    assign bus.wb_adr_o = ADDR_W'(req_q.adr);
    assign bus.wb_dat_o = req_q.dat;
    assign bus.wb_sel_o = req_q.sel;

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - directed scoreboard bench for wb_master_bridge
module tb_wb_master_bridge;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   failures;
    int   edge_n;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t exp_q[$];

    wb_master_bridge_if #(.ADDR_W(32)) bus ();

    wb_master_bridge #(
        .ADDR_W  (32),
        .TIMEOUT (4),
        .TO_W    (3)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_at, input int err_at,
                           input logic [31:0] rdat, input int exp_cyc,
                           input logic exp_err, input logic [31:0] exp_dat, input int hold);
        int   ncyc;
        int   t0;
        rsp_t got;
        rsp_t want;
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready_o, 1);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_adr_i   = adr;
        bus.req_dat_i   = dat;
        bus.req_sel_i   = sel;
        exp_q.push_back('{err: exp_err, dat: exp_dat});
        t0 = edge_n;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_adr_i   = 32'hFFFF_FFFF;
        bus.req_dat_i   = 32'h0;
        bus.req_we_i    = ~we;
        ncyc = 0;
        while (bus.wb_cyc_o === 1'b1 && ncyc < 40) begin
            ncyc++;
            chk("stb", bus.wb_stb_o, 1);
            chk("we", bus.wb_we_o, we);
            chk("adr", bus.wb_adr_o, adr);
            chk("dat_o", bus.wb_dat_o, dat);
            chk("sel", bus.wb_sel_o, sel);
            chk("ready_bus", bus.req_ready_o, 0);
            chk("rsp_valid_bus", bus.rsp_valid_o, 0);
            bus.wb_ack_i = (ncyc == ack_at);
            bus.wb_err_i = (ncyc == err_at);
            bus.wb_dat_i = rdat;
            @(negedge clk);
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_dat_i = 32'h0BAD_0BAD;
        end
        chk("cyc_len", ncyc, exp_cyc);
        chk("stb_low", bus.wb_stb_o, 0);
        chk("rsp_valid", bus.rsp_valid_o, 1);
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = '{err: bus.rsp_err_o, dat: bus.rsp_dat_o};
            chk("rsp_err", got.err, want.err);
            chk("rsp_dat", got.dat, want.dat);
        end else begin
            want = '{err: exp_err, dat: exp_dat};
        end
        for (int i = 0; i < hold; i++) begin
            bus.req_valid_i = 1'b1;
            bus.req_adr_i   = 32'h3000_0100 + 32'(i);
            bus.wb_ack_i    = (i == 3);
            bus.wb_err_i    = (i == 6);
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid_o, 1);
            chk("hold_err", bus.rsp_err_o, want.err);
            chk("hold_dat", bus.rsp_dat_o, want.dat);
            chk("hold_ready", bus.req_ready_o, 0);
            chk("hold_cyc", bus.wb_cyc_o, 0);
        end
        bus.req_valid_i = 1'b0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk("rsp_valid_drop", bus.rsp_valid_o, 0);
        chk("busy_idle", busy, 0);
        chk("ready_back", bus.req_ready_o, 1);
        chk("turnaround", edge_n - t0, 2 + exp_cyc + hold);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        edge_n          = 0;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_adr_i   = '0;
        bus.req_dat_i   = '0;
        bus.req_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wb_dat_i    = '0;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;
        #1;
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready_o, 1);

        // read, ack on 2nd BUS cycle
        run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, 2, 1'b0, 32'hDEAD_BEEF, 0);
        // write, zero-wait ack; read data on the bus must not leak into the response
        run_txn(1'b1, 32'h3000_0010, 32'h1234_5678, 4'b0011, 1, 0, 32'hFFFF_FFFF, 1, 1'b0, 32'h0, 0);
        // no termination: timeout after 5 BUS cycles
        run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 0, 32'h5555_5555, 5, 1'b1, 32'h0, 0);
        // ack coincides with counter match: ack wins
        run_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, 5, 0, 32'hCAFE_F00D, 5, 1'b0, 32'hCAFE_F00D, 0);
        // ack and err together
        run_txn(1'b0, 32'h3000_0028, 32'h0, 4'hF, 1, 1, 32'h7777_7777, 1, 1'b1, 32'h0, 0);
        // err alone on 3rd cycle of a write
        run_txn(1'b1, 32'h3000_002C, 32'hAAAA_0000, 4'b1000, 0, 3, 32'h0, 3, 1'b1, 32'h0, 0);
        // response held back 10 cycles with pending request and spurious ack/err
        run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 3, 0, 32'hA5A5_5A5A, 3, 1'b0, 32'hA5A5_5A5A, 10);

        // reset mid-BUS
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_adr_i   = 32'h3000_0040;
        bus.req_sel_i   = 4'hF;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("mid_cyc_before", bus.wb_cyc_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cyc", bus.wb_cyc_o, 0);
        chk("async_stb", bus.wb_stb_o, 0);
        chk("async_busy", busy, 0);
        chk("async_rsp", bus.rsp_valid_o, 0);
        @(negedge clk);
        bus.wb_ack_i = 1'b1;
        @(negedge clk);
        bus.wb_ack_i = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rsp", bus.rsp_valid_o, 0);
            chk("post_rst_cyc", bus.wb_cyc_o, 0);
            chk("post_rst_ready", bus.req_ready_o, 1);
        end
        run_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 1, 0, 32'h0123_4567, 1, 1'b0, 32'h0123_4567, 0);

        chk("q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
